// File: rtl/onchip_ram_pipelined.sv
// Parametrised single-clock Avalon-MM slave on-chip RAM.
// Supports byte-lane writes, a pipelined read path with readdatavalid
// (latency 1 or 2), waitrequest back-pressure, an optional zero-clear
// sweep after reset and out-of-range access detection.
module onchip_ram_pipelined #(
    parameter int    DATA_WIDTH     = 128,
    parameter int    ADDR_WIDTH     = 15,
    parameter int    DEPTH          = 18750,
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    clear_done,
    output logic                    range_err
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RST,
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    en;
    logic                    in_range;
    logic                    accept;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    sweep_we;
    logic                    ram_we;
    logic                    ram_re;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [IDX_W-1:0]        ram_idx;
    logic [BE_W-1:0]         ram_be;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    v1;
    logic                    zero1;
    logic                    rdv_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign en          = clken & ~reset_req;
    assign waitrequest = ~((state == ST_RUN) & en);
    assign clear_done  = (state == ST_RUN);
    assign in_range    = ({1'b0, address} < DEPTH_X);
    assign accept      = chipselect & ~waitrequest & (read | write);
    // A combined read+write performs only the write.
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & read & ~write;

    // Single RAM port shared between the clear sweep and bus traffic;
    // the two never overlap because waitrequest is high while sweeping.
    assign sweep_we  = (state == ST_CLEAR) & en;
    assign ram_we    = sweep_we | (wr_acc & in_range);
    assign ram_re    = rd_acc & in_range;
    assign ram_addr  = sweep_we ? cnt : address;
    assign ram_idx   = ram_addr[IDX_W-1:0];
    assign ram_be    = sweep_we ? '1 : byteenable;
    assign ram_wdata = sweep_we ? '0 : writedata;

    // State register and sweep counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= ST_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (sweep_we) cnt <= cnt + 1'b1;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch
        // is inferred.
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ST_CLEAR: if (en && (cnt == LAST_ADDR)) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_RST;
        endcase
    end

    // RAM array with byte-lane writes and registered read.
    always_ff @(posedge clk) begin
        // NOTE: the array and its read register have no reset so the
        // memory maps onto block RAM; zeroing is done by the sweep.
        if (ram_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (ram_re) ram_q <= mem[ram_idx];
    end

    // First read stage: valid bit, force-zero flag for out-of-range reads,
    // and the range error pulse. zero1 resets high so readdata starts at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            zero1     <= 1'b1;
            range_err <= 1'b0;
        end else begin
            range_err <= accept & ~in_range;
            if (en)     v1    <= rd_acc;
            if (rd_acc) zero1 <= ~in_range;
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign rdv_q    = v1;
            assign readdata = zero1 ? '0 : ram_q;
        end else begin : g_lat2
            logic                  v2;
            logic [DATA_WIDTH-1:0] rdata_q;

            // Output register stage; holds data between valid pulses.
            always_ff @(posedge clk) begin
                if (reset) begin
                    v2      <= 1'b0;
                    rdata_q <= '0;
                end else if (en) begin
                    v2 <= v1;
                    if (v1) rdata_q <= zero1 ? '0 : ram_q;
                end
            end

            assign rdv_q    = v2;
            assign readdata = rdata_q;
        end
    endgenerate

    // A pending result is held while disabled and shown on the next
    // enabled cycle, so latency is counted in enabled cycles.
    assign readdatavalid = rdv_q & en;

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Self-checking bench: two DUTs (read latency 1 and 2) share the same
// stimulus; each has its own expected-response queue and monitor.
module tb_onchip_ram_pipelined;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            ecnt;
    } resp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            reset_req = 1'b0;
    logic            clken = 1'b1;
    logic            chipselect = 1'b0;
    logic            read = 1'b0;
    logic            write = 1'b0;
    logic [AW-1:0]   address = '0;
    logic [DW/8-1:0] byteenable = '0;
    logic [DW-1:0]   writedata = '0;

    logic [DW-1:0]   rdata [2];
    logic            rdv [2];
    logic            wreq [2];
    logic            cdone [2];
    logic            rerr [2];

    resp_t q0[$];
    resp_t q1[$];
    int    en_cnt = 0;
    logic  exp_rerr = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;

    always #5 clk = ~clk;

    onchip_ram_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_FILE("onchip_ram.hex")
    ) u_lat1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .chipselect(chipselect), .read(read), .write(write),
        .address(address), .byteenable(byteenable), .writedata(writedata),
        .readdata(rdata[0]), .readdatavalid(rdv[0]), .waitrequest(wreq[0]),
        .clear_done(cdone[0]), .range_err(rerr[0])
    );

    onchip_ram_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1), .INIT_FILE("onchip_ram.hex")
    ) u_lat2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .chipselect(chipselect), .read(read), .write(write),
        .address(address), .byteenable(byteenable), .writedata(writedata),
        .readdata(rdata[1]), .readdatavalid(rdv[1]), .waitrequest(wreq[1]),
        .clear_done(cdone[1]), .range_err(rerr[1])
    );

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Count enabled cycles; a read accepted with count E must return when
    // the count reads E + latency.
    always @(posedge clk) begin
        if (clken && !reset_req) en_cnt <= en_cnt + 1;
        exp_rerr <= !reset && chipselect && (read || write) && clken &&
                    !reset_req && (address >= AW'(DEPTH));
    end

    task automatic mon(input int d);
        resp_t e;
        int    sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (rdv[d]) begin
            if (sz == 0) begin
                check($sformatf("dut%0d unexpected readdatavalid", d), 64'(rdv[d]), 64'd0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("dut%0d readdata", d), rdata[d], e.data);
                check($sformatf("dut%0d latency", d), 64'(en_cnt - e.ecnt), 64'(d + 1));
            end
        end
        check($sformatf("dut%0d range_err", d), 64'(rerr[d]), 64'(exp_rerr));
    endtask

    // Monitors sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW/8-1:0] be,
                      input logic [DW-1:0] d);
        chipselect = 1'b1;
        read       = 1'b0;
        write      = 1'b1;
        address    = a;
        byteenable = be;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        q0.push_back('{data: exp, ecnt: en_cnt});
        q1.push_back('{data: exp, ecnt: en_cnt});
        chipselect = 1'b1;
        read       = 1'b0;
        read       = 1'b1;
        write      = 1'b0;
        address    = a;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    // Called at the start of the RST cycle right after reset is released.
    task automatic wait_clear();
        int n = 0;
        @(negedge clk);
        check("rst cycle clear_done", 64'(cdone[0]), 64'd0);
        check("rst cycle waitrequest", 64'(wreq[1]), 64'd1);
        while (n < 100) begin
            @(negedge clk);
            if (cdone[0]) break;
            n++;
        end
        check("sweep length", 64'(n), 64'(DEPTH));
        check("lat2 clear_done", 64'(cdone[1]), 64'd1);
        check("lat1 waitrequest after sweep", 64'(wreq[0]), 64'd0);
        check("lat2 waitrequest after sweep", 64'(wreq[1]), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input logic use_req);
        for (int i = 0; i < 3; i++) begin
            if (use_req) reset_req = 1'b1;
            else         clken     = 1'b0;
            @(negedge clk);
            check("stall waitrequest lat1", 64'(wreq[0]), 64'd1);
            check("stall waitrequest lat2", 64'(wreq[1]), 64'd1);
            check("stall no readdatavalid", 64'(rdv[0] | rdv[1]), 64'd0);
            @(posedge clk);
            #1;
        end
        reset_req = 1'b0;
        clken     = 1'b1;
    endtask

    initial begin
        // Reset held for three cycles.
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset readdata", d), rdata[d], 64'd0);
            check($sformatf("dut%0d reset readdatavalid", d), 64'(rdv[d]), 64'd0);
            check($sformatf("dut%0d reset waitrequest", d), 64'(wreq[d]), 64'd1);
            check($sformatf("dut%0d reset clear_done", d), 64'(cdone[d]), 64'd0);
        end
        tick();
        reset = 1'b0;
        wait_clear();

        // Swept memory reads back as zero.
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 64'd0);
        idle(3);

        // Preload value = addr, then an 8-read back-to-back burst.
        for (int i = 0; i < 8; i++) wr(AW'(i), 8'hFF, 64'(i));
        for (int i = 0; i < 8; i++) rd(AW'(i), 64'(i));
        idle(3);

        // Byte-lane writes.
        wr(5'd5, 8'hFF, 64'hDEADBEEF_00000001);
        wr(5'd5, 8'h01, 64'h12345678_9ABCDEAA);
        rd(5'd5, 64'hDEADBEEF_000000AA);
        wr(5'd5, 8'hF0, 64'h01234567_FFFFFFFF);
        rd(5'd5, 64'h01234567_000000AA);
        // Read in the cycle right after a write to the same address.
        wr(5'd9, 8'hFF, 64'hCAFEF00D_0BADC0DE);
        rd(5'd9, 64'hCAFEF00D_0BADC0DE);
        idle(3);

        // Out-of-range read and write; empty byteenable is a no-op.
        rd(5'd20, 64'd0);
        wr(5'd20, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
        rd(5'd4, 64'd4);
        wr(5'd4, 8'h00, 64'hFFFFFFFF_FFFFFFFF);
        rd(5'd4, 64'd4);
        idle(3);

        // Pipeline stall after acceptance, by clken then by reset_req.
        rd(5'd7, 64'd7);
        stall(1'b0);
        idle(4);
        rd(5'd6, 64'd6);
        stall(1'b1);
        idle(4);

        // Reset mid-sweep at cnt=7, then a full restart.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_clear();

        // Combined read+write: write happens, no readdatavalid.
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b1;
        address    = 5'd3;
        byteenable = 8'hFF;
        writedata  = 64'h55555555_55555555;
        tick();
        idle(4);
        for (int i = 0; i < DEPTH; i++)
            rd(AW'(i), (i == 3) ? 64'h55555555_55555555 : 64'd0);
        idle(8);

        check("lat1 responses outstanding", 64'(q0.size()), 64'd0);
        check("lat2 responses outstanding", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
